mem_copy_dma: RTL and testbench

//  Initiator-side engine for the 8-bit data_memory port. It copies a block of words inside
//  the data memory from a source address to a destination address.
//  - Drives address/writedata/memread/memwrite itself; takes readdata back from the memory.
//  - Sits beside the CPU datapath, which owns start/abort and arbitrates the memory port.
//  - Each word takes one read cycle followed by one write cycle.

---
 rtl/mem_copy_dma.sv | 158 +++++++++++++++
 tb/tb_mem_copy_dma.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_dma
//  Description : Block-copy engine for the 8-bit data memory port. It copies
//                `length` words from src_addr to dst_addr. Each word takes one
//                read cycle and then one write cycle. Addresses wrap modulo
//                MEM_DEPTH. All outputs are driven from registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_dma #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 32,
    parameter int LEN_W     = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_copied
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0]  C_MAX_LEN = LEN_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] C_DEPTH   = ADDR_W'(MEM_DEPTH);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;

    logic [LEN_W-1:0]    w_len_clamped;
    logic [LEN_W-1:0]    w_idx_next;

    // Base plus word offset, summed at address width and then wrapped into the memory.
    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]  off);
        logic [ADDR_W-1:0] sum;
        sum = base + ADDR_W'(off);
        return sum % C_DEPTH;
    endfunction

    // Lengths beyond the memory size are clamped; index of the following word.
    always_comb begin
        w_len_clamped = (length > C_MAX_LEN) ? C_MAX_LEN : length;
        w_idx_next    = r_idx + 1'b1;
    end

    // Copy FSM. Outputs are registered, so each transition sets the values that
    // belong to the state being entered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_src         <= '0;
            r_dst         <= '0;
            r_len         <= '0;
            r_idx         <= '0;
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_memread   <= 1'b0;
            mem_memwrite  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_copied  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done         <= 1'b0;
                    mem_memread  <= 1'b0;
                    mem_memwrite <= 1'b0;
                    busy         <= 1'b0;
                    // start takes priority over a simultaneous abort
                    if (start) begin
                        r_src        <= src_addr;
                        r_dst        <= dst_addr;
                        r_len        <= w_len_clamped;
                        r_idx        <= '0;
                        words_copied <= '0;
                        if (w_len_clamped == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state     <= S_READ;
                            busy        <= 1'b1;
                            mem_memread <= 1'b1;
                            mem_address <= wrap_addr(src_addr, '0);
                        end
                    end
                end

                S_READ: begin
                    mem_memread <= 1'b0;
                    if (abort) begin
                        // word in flight is dropped, nothing is written
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state       <= S_WRITE;
                        mem_writedata <= mem_readdata;
                        mem_address   <= wrap_addr(r_dst, r_idx);
                        mem_memwrite  <= 1'b1;
                    end
                end

                S_WRITE: begin
                    // the write commits at this edge regardless of abort
                    mem_memwrite <= 1'b0;
                    words_copied <= words_copied + 1'b1;
                    r_idx        <= w_idx_next;
                    if (abort) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (w_idx_next == r_len) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state     <= S_READ;
                        mem_memread <= 1'b1;
                        mem_address <= wrap_addr(r_src, w_idx_next);
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state      <= S_IDLE;
                    mem_memread  <= 1'b0;
                    mem_memwrite <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_copy_dma
//  Description : Self-checking bench for mem_copy_dma with a behavioural
//                data memory, a directed vector table, randomized copies
//                against a reference model, and abort/reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_copy_dma;

    localparam int DEPTH = 32;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    logic       abort;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [5:0] length;
    logic [7:0] mem_readdata;
    logic [7:0] mem_address;
    logic [7:0] mem_writedata;
    logic       mem_memread;
    logic       mem_memwrite;
    logic       busy;
    logic       done;
    logic [5:0] words_copied;

    int vectors    = 0;
    int miscompares = 0;

    mem_copy_dma #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .MEM_DEPTH(DEPTH),
        .LEN_W    (6)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .start        (start),
        .abort        (abort),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length       (length),
        .mem_readdata (mem_readdata),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .busy         (busy),
        .done         (done),
        .words_copied (words_copied)
    );

    always #5 CLK = ~CLK;

    // Behavioural data memory: combinational read, write at posedge, bulk load.
    logic [7:0] mem      [DEPTH];
    logic [7:0] load_img [DEPTH];
    logic       load_en;

    assign mem_readdata = mem[int'(mem_address) % DEPTH];

    always @(posedge CLK) begin
        if (load_en) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= load_img[k];
        end else if (mem_memwrite) begin
            mem[int'(mem_address) % DEPTH] <= mem_writedata;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_memory();
        @(negedge CLK);
        load_en = 1'b1;
        @(negedge CLK);
        load_en = 1'b0;
    endtask

    task automatic preload_identity();
        for (int k = 0; k < DEPTH; k++) load_img[k] = 8'(k);
        load_memory();
    endtask

    // Issue one copy and watch every cycle until done. Strobes, addresses and
    // busy are compared against the expected R,W,R,W,... pattern.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [5:0] len,
                            output int lat, output int wc, output int proto_err);
        int n;
        int j;
        n = (int'(len) > DEPTH) ? DEPTH : int'(len);
        lat = -1;
        wc = -1;
        proto_err = 0;
        @(negedge CLK);
        src_addr = s;
        dst_addr = d;
        length   = len;
        start    = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge CLK);
            if (done) begin
                lat = k;
                wc  = int'(words_copied);
                if (busy || mem_memread || mem_memwrite) proto_err++;
                break;
            end
            if (k > 2 * n) begin
                proto_err++;
            end else begin
                j = (k - 1) / 2;
                if (!busy) proto_err++;
                if (k % 2 == 1) begin
                    if (!mem_memread || mem_memwrite) proto_err++;
                    if (int'(mem_address) != (int'(s) + j) % DEPTH) proto_err++;
                end else begin
                    if (mem_memread || !mem_memwrite) proto_err++;
                    if (int'(mem_address) != (int'(d) + j) % DEPTH) proto_err++;
                end
            end
        end
        @(negedge CLK);
        if (done || busy) proto_err++;
    endtask

    typedef struct {
        logic [7:0]      src;
        logic [7:0]      dst;
        logic [5:0]      len;
        int              exp_lat;
        int              exp_wc;
        int              chk_base;
        logic [3:0][7:0] chk_val;
    } vec_t;

    vec_t tbl [5];

    logic [7:0] model [DEPTH];
    int lat, wc, perr, n, bad, done_seen;
    logic [7:0] rs, rd;
    logic [5:0] rl;

    initial begin
        RESET    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        load_en  = 1'b0;

        tbl[0] = '{8'd0,  8'd16, 6'd4,  9,  4,  16, {8'd3,  8'd2,  8'd1,  8'd0}};
        tbl[1] = '{8'd0,  8'd30, 6'd4,  9,  4,  30, {8'd3,  8'd2,  8'd1,  8'd0}};
        tbl[2] = '{8'd0,  8'd1,  6'd3,  7,  3,  0,  {8'd0,  8'd0,  8'd0,  8'd0}};
        tbl[3] = '{8'd0,  8'd8,  6'd0,  1,  0,  8,  {8'd11, 8'd10, 8'd9,  8'd8}};
        tbl[4] = '{8'd8,  8'd0,  6'd40, 65, 32, 24, {8'd11, 8'd10, 8'd9,  8'd8}};

        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_address",   int'(mem_address),   0);
        check("rst_writedata", int'(mem_writedata), 0);
        check("rst_memread",   int'(mem_memread),   0);
        check("rst_memwrite",  int'(mem_memwrite),  0);
        check("rst_busy",      int'(busy),          0);
        check("rst_done",      int'(done),          0);
        check("rst_words",     int'(words_copied),  0);
        RESET = 1'b0;

        // directed vector table
        for (int v = 0; v < 5; v++) begin
            preload_identity();
            run_copy(tbl[v].src, tbl[v].dst, tbl[v].len, lat, wc, perr);
            check($sformatf("tbl%0d_latency", v), lat, tbl[v].exp_lat);
            check($sformatf("tbl%0d_words", v), wc, tbl[v].exp_wc);
            check($sformatf("tbl%0d_protocol", v), perr, 0);
            for (int k = 0; k < 4; k++)
                check($sformatf("tbl%0d_mem[%0d]", v, (tbl[v].chk_base + k) % DEPTH),
                      int'(mem[(tbl[v].chk_base + k) % DEPTH]), int'(tbl[v].chk_val[k]));
        end

        // randomized copies against a forward word-by-word reference model
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < DEPTH; k++) begin
                load_img[k] = 8'($urandom);
                model[k]    = load_img[k];
            end
            load_memory();
            rs = 8'($urandom);
            rd = 8'($urandom);
            rl = 6'($urandom_range(0, 34));
            n  = (int'(rl) > DEPTH) ? DEPTH : int'(rl);
            for (int k = 0; k < n; k++)
                model[(int'(rd) + k) % DEPTH] = model[(int'(rs) + k) % DEPTH];
            run_copy(rs, rd, rl, lat, wc, perr);
            check($sformatf("rnd%0d_latency", t), lat, 2 * n + 1);
            check($sformatf("rnd%0d_words", t), wc, n);
            check($sformatf("rnd%0d_protocol", t), perr, 0);
            bad = 0;
            for (int k = 0; k < DEPTH; k++) if (mem[k] !== model[k]) bad++;
            check($sformatf("rnd%0d_mem_bad_words", t), bad, 0);
        end

        // restart ignored mid-copy, abort during the third READ
        preload_identity();
        @(negedge CLK);
        src_addr = 8'd0; dst_addr = 8'd16; length = 6'd8; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;                       // cycle 1: READ
        @(negedge CLK);
        start = 1'b1;                       // cycle 2: WRITE, must be ignored
        src_addr = 8'd5; dst_addr = 8'd25; length = 6'd1;
        @(negedge CLK);
        start = 1'b0;                       // cycle 3: READ
        @(negedge CLK);                     // cycle 4: WRITE
        @(negedge CLK);                     // cycle 5: third READ
        check("abort_third_read", int'(mem_memread), 1);
        check("abort_read_addr", int'(mem_address), 2);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_strobes", int'({mem_memread, mem_memwrite}), 0);
        check("abort_words", int'(words_copied), 2);
        done_seen = int'(done);
        repeat (5) begin
            @(negedge CLK);
            done_seen += int'(done);
        end
        check("abort_no_done", done_seen, 0);
        check("abort_mem16", int'(mem[16]), 0);
        check("abort_mem17", int'(mem[17]), 1);
        check("abort_mem18", int'(mem[18]), 18);

        // reset during the second WRITE, then a fresh copy
        preload_identity();
        @(negedge CLK);
        src_addr = 8'd0; dst_addr = 8'd16; length = 6'd4; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;                       // cycle 1
        repeat (3) @(negedge CLK);          // cycle 4: second WRITE
        check("rstmid_in_write", int'(mem_memwrite), 1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("rstmid_outputs",
              int'({mem_address, mem_writedata, mem_memread, mem_memwrite, busy, done, words_copied}), 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge CLK);
            done_seen += int'(done) + int'(mem_memwrite);
        end
        check("rstmid_quiet", done_seen, 0);
        run_copy(8'd4, 8'd20, 6'd2, lat, wc, perr);
        check("rstmid_new_latency", lat, 5);
        check("rstmid_new_words", wc, 2);
        check("rstmid_new_protocol", perr, 0);
        check("rstmid_mem20", int'(mem[20]), 4);
        check("rstmid_mem21", int'(mem[21]), 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
